// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional bypass path is enabled with FETCH_BUFFER_BYPASS_EN (see fetch_buffer).
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN,
        DRAIN
    } fetch_state_e;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned PC_STEP = 4;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered storage array, flush, and extra-MSB pointers.
// DEPTH must be a power of two >= 2.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = logic [63:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  entry_t                 wdata_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        // Flush wins over a same-cycle push/pop.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: sequential PC, credit-limited imem requests, PC-tagged response FIFO to decode.
// Define FETCH_BUFFER_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [DATA_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [DATA_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]  imem_rsp_data,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [DATA_WIDTH-1:0]  dec_instr,
    output logic [DATA_WIDTH-1:0]  dec_pc,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [DATA_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [DATA_WIDTH-1:0] target_pc;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           credits_used;
    logic                  run, req_fire, rsp_take, bypass, push, pop;
    logic                  fifo_full, fifo_empty;
    entry_t                push_entry, head;

    assign target_pc    = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
    assign run          = (state_q == RUN);
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};

    // Every outstanding request owns a FIFO slot, so responses can never overflow it.
    assign imem_req_valid = !rst && run && !redirect && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses in DRAIN or in a redirect cycle belong to the squashed path.
    assign rsp_take = imem_rsp_valid && run && !redirect;

`ifdef FETCH_BUFFER_BYPASS_EN
    assign bypass = rsp_take && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    assign push       = rsp_take && !(bypass && dec_ready);
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
    assign dec_valid  = !rst && run && (!fifo_empty || bypass);
    assign pop        = dec_valid && dec_ready && !fifo_empty;
    assign occupancy  = fifo_count;

    always_comb begin
        dec_instr = '0;
        dec_pc    = '0;
        if (dec_valid) begin
            if (bypass) begin
                dec_instr = imem_rsp_data;
                dec_pc    = rsp_pc_q;
            end else begin
                dec_instr = head.instr;
                dec_pc    = head.pc;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_STEP);
            if (rsp_take) rsp_pc_d = rsp_pc_q + DATA_WIDTH'(PC_STEP);
        end
        case (state_q)
            RUN:     if (redirect && inflight_d != '0) state_d = DRAIN;
            DRAIN:   if (!redirect && inflight_d == '0) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && inflight_q == '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: per-cycle vector table plus redirect/reset/wrap sequences.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  occupancy;

    fetch_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mem_lat = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] req_log[$];
    logic [31:0] dec_log[$];

    // Memory model: in-order, fixed latency, instruction word = ~address.
    always begin
        @(negedge clk);
        if (rst) begin
            pend.delete();
        end else begin
            if (imem_rsp_valid) void'(pend.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                req_log.push_back(imem_req_addr);
            end
            if (dec_valid && dec_ready) dec_log.push_back(dec_pc);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~pend[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    typedef struct {
        logic        rdy;
        logic        drdy;
        logic        ev;
        logic [31:0] eaddr;
        logic        edv;
        logic [31:0] epc;
        logic [2:0]  eocc;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic rdy, input logic drdy, input logic ev,
                                input logic [31:0] eaddr, input logic edv,
                                input logic [31:0] epc, input logic [2:0] eocc);
        vec_t v;
        v.rdy = rdy; v.drdy = drdy; v.ev = ev; v.eaddr = eaddr;
        v.edv = edv; v.epc = epc; v.eocc = eocc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_valid"}, imem_req_valid, 0);
        chk({tag, "_dec_valid"}, dec_valid, 0);
        chk({tag, "_dec_instr"}, dec_instr, 0);
        chk({tag, "_dec_pc"}, dec_pc, 0);
        chk({tag, "_occupancy"}, occupancy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        dec_ready = 1'b1;
        next_cyc();
        @(negedge clk);
        chk_idle("reset");
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int max, output logic ok, output logic [31:0] addr);
        ok = 1'b0;
        addr = '0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (imem_req_valid) begin
                ok = 1'b1;
                addr = imem_req_addr;
            end
            next_cyc();
        end
    endtask

    task automatic wait_dec(input int max, output logic ok, output logic [31:0] pc,
                            output logic [31:0] instr);
        ok = 1'b0;
        pc = '0;
        instr = '0;
        for (int i = 0; i < max && !ok; i++) begin
            @(negedge clk);
            if (dec_valid) begin
                ok = 1'b1;
                pc = dec_pc;
                instr = dec_instr;
            end
            next_cyc();
        end
    endtask

    // Issue two requests at mem_lat=3, then redirect while both are outstanding.
    task automatic two_inflight_then_redirect(input logic [31:0] tgt);
        do_reset();
        mem_lat = 3;
        next_cyc();
        next_cyc();
        imem_req_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        chk("redirect_withdraws_req", imem_req_valid, 0);
        next_cyc();
    endtask

    initial begin
        logic        ok;
        logic [31:0] a, pc, ins;
        int          base, base_d;

        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        dec_ready = 1'b0;

        //              rdy drdy ev addr          dv pc            occ
        vecs[0]  = mk(1, 1, 1, 32'h00, 0, 32'h00, 0);
        vecs[1]  = mk(1, 1, 1, 32'h04, 0, 32'h00, 0);
        vecs[2]  = mk(1, 1, 1, 32'h08, 1, 32'h00, 1);
        vecs[3]  = mk(1, 1, 1, 32'h0C, 1, 32'h04, 1);
        vecs[4]  = mk(1, 1, 1, 32'h10, 1, 32'h08, 1);
        vecs[5]  = mk(1, 1, 1, 32'h14, 1, 32'h0C, 1);
        vecs[6]  = mk(1, 0, 1, 32'h18, 1, 32'h10, 1);
        vecs[7]  = mk(1, 0, 1, 32'h1C, 1, 32'h10, 2);
        vecs[8]  = mk(1, 0, 0, 32'h00, 1, 32'h10, 3);
        vecs[9]  = mk(1, 0, 0, 32'h00, 1, 32'h10, 4);
        vecs[10] = mk(1, 1, 0, 32'h00, 1, 32'h10, 4);
        vecs[11] = mk(1, 1, 1, 32'h20, 1, 32'h14, 3);
        vecs[12] = mk(1, 1, 1, 32'h24, 1, 32'h18, 2);
        vecs[13] = mk(1, 1, 1, 32'h28, 1, 32'h1C, 2);
        vecs[14] = mk(1, 1, 1, 32'h2C, 1, 32'h20, 2);

        next_cyc();
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 15; i++) begin
            imem_req_ready = vecs[i].rdy;
            dec_ready = vecs[i].drdy;
            @(negedge clk);
            chk($sformatf("row%0d_req_valid", i), imem_req_valid, vecs[i].ev);
            if (vecs[i].ev) chk($sformatf("row%0d_req_addr", i), imem_req_addr, vecs[i].eaddr);
            chk($sformatf("row%0d_dec_valid", i), dec_valid, vecs[i].edv);
            if (vecs[i].edv) begin
                chk($sformatf("row%0d_dec_pc", i), dec_pc, vecs[i].epc);
                chk($sformatf("row%0d_dec_instr", i), dec_instr, ~vecs[i].epc);
            end
            chk($sformatf("row%0d_occupancy", i), occupancy, vecs[i].eocc);
            next_cyc();
        end

        // Decode stalled from reset: exactly DEPTH requests, then credits run out.
        do_reset();
        mem_lat = 1;
        dec_ready = 1'b0;
        base = req_log.size();
        repeat (8) next_cyc();
        chk("stall_req_count", req_log.size() - base, 4);
        @(negedge clk);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_occupancy", occupancy, 4);
        next_cyc();
        dec_ready = 1'b1;
        repeat (4) next_cyc();
        chk("stall_resumes", (req_log.size() - base) > 4, 1);

        // Redirect with two responses owed: drain, then fetch target.
        two_inflight_then_redirect(32'h100);
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("drain1_req_valid", imem_req_valid, 0);
        chk("drain1_dec_valid", dec_valid, 0);
        next_cyc();
        @(negedge clk);
        chk("drain2_req_valid", imem_req_valid, 0);
        next_cyc();
        @(negedge clk);
        chk("after_drain_req_valid", imem_req_valid, 1);
        chk("after_drain_req_addr", imem_req_addr, 32'h100);
        next_cyc();
        wait_dec(12, ok, pc, ins);
        chk("redir_dec_seen", ok, 1);
        chk("redir_dec_pc", pc, 32'h100);
        chk("redir_dec_instr", ins, ~32'h100);

        // Unaligned target: low bits dropped.
        redirect = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        next_cyc();
        redirect = 1'b0;
        wait_req(20, ok, a);
        chk("unaligned_req_seen", ok, 1);
        chk("unaligned_req_addr", a, 32'h200);
        wait_dec(20, ok, pc, ins);
        chk("unaligned_dec_seen", ok, 1);
        chk("unaligned_dec_pc", pc, 32'h200);

        // Second redirect while draining: only the latest target is fetched.
        two_inflight_then_redirect(32'h40);
        redirect_pc = 32'h80;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("double_redir_req_valid", imem_req_valid, 0);
        next_cyc();
        redirect = 1'b0;
        base = req_log.size();
        wait_req(10, ok, a);
        chk("double_redir_req_seen", ok, 1);
        chk("double_redir_req_addr", a, 32'h80);
        chk("double_redir_first_accepted",
            (req_log.size() > base) ? req_log[base] : 32'hDEAD_BEEF, 32'h80);

        // Reset while draining.
        two_inflight_then_redirect(32'h100);
        redirect = 1'b0;
        imem_req_ready = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_drain_a");
        next_cyc();
        @(negedge clk);
        chk_idle("rst_drain_b");
        next_cyc();
        rst = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        chk("post_rst_req_valid", imem_req_valid, 1);
        chk("post_rst_req_addr", imem_req_addr, 32'h0);
        next_cyc();

        // Address wrap through the top of the space.
        do_reset();
        mem_lat = 1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        base = req_log.size();
        base_d = dec_log.size();
        next_cyc();
        redirect = 1'b0;
        repeat (6) next_cyc();
        if (req_log.size() >= base + 3) begin
            chk("wrap_req0", req_log[base], 32'hFFFF_FFF8);
            chk("wrap_req1", req_log[base+1], 32'hFFFF_FFFC);
            chk("wrap_req2", req_log[base+2], 32'h0000_0000);
        end else begin
            chk("wrap_req_count", req_log.size() - base, 3);
        end
        if (dec_log.size() >= base_d + 3) begin
            chk("wrap_dec0", dec_log[base_d], 32'hFFFF_FFF8);
            chk("wrap_dec1", dec_log[base_d+1], 32'hFFFF_FFFC);
            chk("wrap_dec2", dec_log[base_d+2], 32'h0000_0000);
        end else begin
            chk("wrap_dec_count", dec_log.size() - base_d, 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Owns the sequential fetch address and issues word requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses, tagged with their PC, in a small FIFO that feeds decode through a valid/ready handshake.
- On a taken branch/jump redirect, flushes all buffered and in-flight instructions and restarts fetch at the target.

Parameters:
- DATA_WIDTH, 32: instruction and address width.
- DEPTH, 4: FIFO entries; power of two, ≥2. Also bounds total entries plus in-flight requests.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- redirect  in  1  taken branch/jump; flush and restart
- redirect_pc  in  DATA_WIDTH  target address; bits [1:0] ignored, forced to 0
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  DATA_WIDTH  word address of request
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, ≥1 cycle after acceptance
- imem_rsp_data  in  DATA_WIDTH  instruction word
- dec_valid  out  1  instruction available to decode
- dec_ready  in  1  decode accepts
- dec_instr  out  DATA_WIDTH  instruction at FIFO head
- dec_pc  out  DATA_WIDTH  PC of dec_instr
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset: clk, with rst synchronous, active-high.
  - During reset and on the first cycle after it: fetch_pc=RESET_PC, state=RUN, FIFO empty, inflight=0, occupancy=0.
  - Outputs: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
  - Asserting rst mid-operation discards everything, including responses still owed by memory. The memory side is also reset; no orphan responses arrive afterwards.
- State machine (RUN, DRAIN):
  - RUN: imem_req_valid = (inflight + occupancy < DEPTH) && !redirect. imem_req_addr = fetch_pc.
  - On a request handshake, fetch_pc += 4 (mod 2^DATA_WIDTH) and inflight += 1.
  - Each response: inflight -= 1. In RUN, push {pc_tag, data}; pc_tag comes from a PC-tag queue or from a response-pc counter advancing by 4.
  - RUN + redirect: flush FIFO, fetch_pc = redirect_pc & ~3, response-pc counter = same value.
    - Next state is DRAIN if the inflight value after this cycle's updates is >0; otherwise RUN.
  - DRAIN: imem_req_valid=0, dec_valid=0. Every response is discarded and decrements inflight. Go to RUN in the cycle after inflight reaches 0.
  - DRAIN + redirect: update fetch_pc and the response-pc counter, remain in DRAIN.
- Credit rule: inflight + occupancy ≤ DEPTH always, so a push into a full FIFO is impossible.
  - An assertion fires on a push into a full FIFO.
  - An assertion fires on imem_rsp_valid with inflight=0.
- Decode side:
  - dec_valid = !empty && state==RUN. Pop on dec_valid && dec_ready.
  - Simultaneous push and pop: occupancy unchanged, pointers both advance.
  - A pop in the redirect cycle completes; that instruction counts as consumed. The flush then clears the rest.
  - A response arriving in the redirect cycle is discarded.
- Latency:
  - Response at cycle N → dec_valid at N+1 (registered FIFO output).
  - Redirect at cycle N with inflight=0 → imem_req_valid at N+1 with addr=target.
- Wrap-around: fetch_pc wraps from 32'hFFFF_FFFC to 0 silently. FIFO pointers wrap mod DEPTH, with an extra MSB for full/empty.
- imem_req_valid, once asserted, holds with a stable address until ready, unless redirect occurs. Redirect may withdraw the request.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN.
- Defined: when the FIFO is empty, state==RUN, redirect=0, and imem_rsp_valid=1, the response is presented combinationally on dec_valid/dec_instr/dec_pc in the same cycle.
  - If dec_ready is high, the entry is not written to the FIFO.
  - Zero-cycle fetch-to-decode latency.
- Undefined: no bypass; minimum latency is 1 cycle as above.

Decomposition:
- Package fetch_pkg:
  - fetch_state_e {RUN, DRAIN}
  - fetch_entry_t struct {pc, instr}
  - localparam PC_STEP = 4
  - localparam INSTR_NOP = 32'h0000_0013, used as the idle value of dec_instr if desired; reset value remains 0.
- Sub-module: sync_fifo (parameterised by DEPTH and entry type) with push, pop, flush, full, empty, count. fetch_buffer holds the FSM, credit logic, and PC tracking.

Test Plan:
- Reset, then memory always ready with 1-cycle response and decode always ready → requests to 0x0, 0x4, 0x8…; dec_pc sequence 0x0, 0x4, 0x8; first dec_valid 2 cycles after the first request (1 with bypass).
- dec_ready=0 with DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0; occupancy=4. Release dec_ready → fetching resumes.
- Memory latency 3 cycles, 2 requests in flight, redirect to 0x100 → next two responses dropped; DRAIN until inflight=0; next request addr=0x100; first dec_pc=0x100.
- Redirect to 0x203 → request addr 0x200.
- Two redirects (0x40, then 0x80) during DRAIN → only 0x80 fetched.
- Reset asserted mid-DRAIN → outputs return to reset values; next request addr=RESET_PC.
- fetch_pc starts at 0xFFFF_FFF8 via redirect → request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- Simultaneous push and pop at occupancy=2 → occupancy stays 2.
